wb_regfile_unit: RTL
====================

Name: wb_regfile_unit

Overview:
- Consumer end of the EX/MEM→WB pipeline register: takes its registered outputs and retires the instruction.
- Selects the writeback value, writes the 16x32 register bank, updates the architectural flag register and counts retired instructions.
- Exposes two combinational read ports with write-through bypass for decode, plus a writeback bus for EX forwarding.

Parameters:
- NREGS, 16, number of architectural registers; address width fixed at 4 (matches in_WC).
- DW, 32, datapath width.
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes; when 0 it is a normal register.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- in_valid  in  1  an instruction is present on the in_* bus this cycle (driven from the pipeline-register ENABLE path).
- in_WC  in  4  destination register address.
- in_PC  in  32  PC of the instruction (link value).
- in_PR  in  32  memory read data.
- in_alu_res  in  32  ALU result.
- in_flags  in  4  ALU flags {N,Z,C,V} = bits [3:0] as [3]=N, [2]=Z, [1]=C, [0]=V.
- in_S_MXRB  in  2  writeback data select.
- in_W_RB  in  1  register bank write enable.
- in_W_RF  in  3  flag write mask.
- in_RA_addr  in  4  read port A address.
- in_RB_addr  in  4  read port B address.
- out_RA  out  32  read port A data, combinational.
- out_RB  out  32  read port B data, combinational.
- out_flags  out  4  architectural flag register.
- out_wb_en  out  1  forwarding: a register write happens this cycle.
- out_wb_addr  out  4  forwarding: destination address (in_WC).
- out_wb_data  out  32  forwarding: selected writeback data.
- out_retired  out  32  retired-instruction counter.

Behaviour:
- Reset: on a rising CLK edge with RESET=1, all NREGS registers are set to 0, out_flags=4'b0 and out_retired=0. Reset has priority over any same-cycle in_valid; nothing is written and the counter is not incremented.
- Writeback select (combinational), wb_data:
  - 00: in_alu_res.
  - 01: in_PR.
  - 10: in_PC.
  - 11: {28'b0, out_flags}, using the current flags before any same-cycle update.
- Write enable:
  - Effective write we = in_valid & in_W_RB & ~(ZERO_REG & in_WC==0).
  - out_wb_en = we, out_wb_addr = in_WC, out_wb_data = wb_data, all combinational.
- Register write: on a clock edge with we=1, reg[in_WC] <= wb_data. The result is visible at the register-array output from the next cycle.
- Read ports:
  - out_RA = 0 if ZERO_REG and in_RA_addr==0.
  - Otherwise out_RA = wb_data if we and in_RA_addr==in_WC (write-through bypass).
  - Otherwise out_RA = reg[in_RA_addr]. out_RB is identical using in_RB_addr.
  - Zero latency; reads are not gated by in_valid.
- Flags, applied only when in_valid=1, and independently of in_W_RB:
  - in_W_RF[2] loads N,Z from in_flags[3:2].
  - in_W_RF[1] loads C from in_flags[1].
  - in_W_RF[0] loads V from in_flags[0].
  - Bits not selected hold their value. New flags are visible on out_flags the cycle after the edge; there is no flag bypass.
- Counter: out_retired increments by 1 on each edge with in_valid=1. It wraps from 0xFFFFFFFF to 0 with no saturation or sticky flag.
- in_valid=0: no register, flag or counter change, whatever in_W_RB and in_W_RF are.
- Reset mid-stream: an instruction on the bus during the reset cycle is dropped. The first post-reset instruction is counted as 1.

Decomposition:
- Shared package pipeline_pkg holds:
  - the S_MXRB encodings (SEL_ALU=2'b00, SEL_MEM=2'b01, SEL_PC=2'b10, SEL_FLAGS=2'b11);
  - the flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0);
  - the W_RF mask bit positions (WRF_NZ=2, WRF_C=1, WRF_V=0).
- One sub-module, reg_bank_2r1w: the register array, synchronous reset, one write port, two bypassed read ports, and ZERO_REG handling.
- Writeback mux, flag register and counter live in the top module.

Test Plan:
- Reset check: hold RESET for 1 cycle, then read every register -> all reads 0, out_flags=0, out_retired=0.
- Write then read, with bypass:
  - Stimulus: in_valid=1, in_W_RB=1, in_WC=5, S_MXRB=00, in_alu_res=0xDEADBEEF, in_RA_addr=5.
  - Same cycle -> out_RA=0xDEADBEEF through the bypass, and out_wb_en=1, out_wb_addr=5.
  - Next cycle, with in_valid=0 -> out_RA=0xDEADBEEF from the array.
- Mux and R0:
  - S_MXRB=01 with in_PR=0x1234 to R3, S_MXRB=10 with in_PC=0x40 to R4 -> R3=0x1234, R4=0x40.
  - Write 0xFFFF to R0 -> R0 reads 0 and out_wb_en=0.
- Partial flag mask: flags=0, then in_flags=4'b1111 with in_W_RF=3'b010 -> out_flags=4'b0010; then S_MXRB=11 to R7 -> R7=0x2.
- Gating: in_valid=0 with in_W_RB=1, in_W_RF=3'b111 -> no register, flag or counter change.
- Counter wrap and reset priority:
  - Force out_retired to 0xFFFFFFFE via 0xFFFFFFFE valid cycles or a bench backdoor, apply 2 valid cycles -> 0x00000000.
  - Assert RESET together with in_valid and a write to R2 -> R2=0, out_retired=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared encodings for the EX/MEM -> WB pipeline slice.
//   - writeback data select codes (in_S_MXRB)
//   - bit positions of N/Z/C/V inside the 4-bit flag word
//   - bit positions of the flag write mask (in_W_RF)
package pipeline_pkg;

    typedef enum logic [1:0] {
        SEL_ALU   = 2'b00,
        SEL_MEM   = 2'b01,
        SEL_PC    = 2'b10,
        SEL_FLAGS = 2'b11
    } wb_sel_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int WRF_NZ = 2;
    localparam int WRF_C  = 1;
    localparam int WRF_V  = 0;

endpackage

// File: rtl/reg_bank_2r1w.sv
// Architectural register array: one write port, two combinational read
// ports with write-through bypass, synchronous active-high reset.
// Ports:
//   i_clk, i_rst           clock, synchronous reset (clears every register)
//   i_we, i_waddr, i_wdata write port (committed on the rising edge)
//   i_raddr_a/b            read addresses
//   o_rdata_a/b            read data (zero for R0 when ZERO_REG != 0)
module reg_bank_2r1w
    import pipeline_pkg::*;
#(
    parameter int NREGS    = 16,
    parameter int DW       = 32,
    parameter int ZERO_REG = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_we,
    input  logic [3:0]    i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [3:0]    i_raddr_a,
    input  logic [3:0]    i_raddr_b,
    output logic [DW-1:0] o_rdata_a,
    output logic [DW-1:0] o_rdata_b
);

    logic [DW-1:0] r_regs [NREGS];
    logic          w_wr_ok;

    // R0 is never written when it is hard-wired, even if the caller forgets
    // to gate the enable.
    assign w_wr_ok = i_we && !((ZERO_REG != 0) && (i_waddr == 4'd0));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Priority: hard-wired zero, then bypass of the in-flight write, then array.
    always_comb begin
        o_rdata_a = r_regs[i_raddr_a];
        if (w_wr_ok && (i_raddr_a == i_waddr)) begin
            o_rdata_a = i_wdata;
        end
        if ((ZERO_REG != 0) && (i_raddr_a == 4'd0)) begin
            o_rdata_a = '0;
        end
    end

    always_comb begin
        o_rdata_b = r_regs[i_raddr_b];
        if (w_wr_ok && (i_raddr_b == i_waddr)) begin
            o_rdata_b = i_wdata;
        end
        if ((ZERO_REG != 0) && (i_raddr_b == 4'd0)) begin
            o_rdata_b = '0;
        end
    end

endmodule

// File: rtl/wb_regfile_unit.sv
// Writeback stage: retires the instruction held in the EX/MEM -> WB pipeline
// register. Selects the writeback value, writes the register bank, updates
// the architectural flags and counts retired instructions.
// Ports:
//   CLK, RESET                 clock, synchronous active-high reset
//   in_valid                   instruction present this cycle
//   in_WC, in_W_RB             destination address, register write enable
//   in_PC, in_PR, in_alu_res   writeback candidates (link, memory, ALU)
//   in_S_MXRB                  writeback select
//   in_flags, in_W_RF          new flags {N,Z,C,V} and per-group write mask
//   in_RA_addr, in_RB_addr     decode read addresses
//   out_RA, out_RB             decode read data (combinational, bypassed)
//   out_flags                  architectural flag register
//   out_wb_en/addr/data        forwarding bus for EX
//   out_retired                retired-instruction counter (wraps)
module wb_regfile_unit
    import pipeline_pkg::*;
#(
    parameter int NREGS    = 16,
    parameter int DW       = 32,
    parameter int ZERO_REG = 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          in_valid,
    input  logic [3:0]    in_WC,
    input  logic [DW-1:0] in_PC,
    input  logic [DW-1:0] in_PR,
    input  logic [DW-1:0] in_alu_res,
    input  logic [3:0]    in_flags,
    input  logic [1:0]    in_S_MXRB,
    input  logic          in_W_RB,
    input  logic [2:0]    in_W_RF,
    input  logic [3:0]    in_RA_addr,
    input  logic [3:0]    in_RB_addr,
    output logic [DW-1:0] out_RA,
    output logic [DW-1:0] out_RB,
    output logic [3:0]    out_flags,
    output logic          out_wb_en,
    output logic [3:0]    out_wb_addr,
    output logic [DW-1:0] out_wb_data,
    output logic [31:0]   out_retired
);

    logic [3:0]    r_flags;
    logic [31:0]   r_retired;
    logic [DW-1:0] w_wb_data;
    logic          w_we;

    // SEL_FLAGS uses the flags as they stand before this cycle's update.
    always_comb begin
        w_wb_data = in_alu_res;
        case (in_S_MXRB)
            SEL_ALU:   w_wb_data = in_alu_res;
            SEL_MEM:   w_wb_data = in_PR;
            SEL_PC:    w_wb_data = in_PC;
            SEL_FLAGS: w_wb_data = {{(DW-4){1'b0}}, r_flags};
            default:   w_wb_data = in_alu_res;
        endcase
    end

    assign w_we = in_valid && in_W_RB && !((ZERO_REG != 0) && (in_WC == 4'd0));

    reg_bank_2r1w #(
        .NREGS    (NREGS),
        .DW       (DW),
        .ZERO_REG (ZERO_REG)
    ) u_bank (
        .i_clk     (CLK),
        .i_rst     (RESET),
        .i_we      (w_we),
        .i_waddr   (in_WC),
        .i_wdata   (w_wb_data),
        .i_raddr_a (in_RA_addr),
        .i_raddr_b (in_RB_addr),
        .o_rdata_a (out_RA),
        .o_rdata_b (out_RB)
    );

    // Flag groups are written independently of the register write enable.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_flags <= 4'b0;
        end else if (in_valid) begin
            if (in_W_RF[WRF_NZ]) begin
                r_flags[FLAG_N] <= in_flags[FLAG_N];
                r_flags[FLAG_Z] <= in_flags[FLAG_Z];
            end
            if (in_W_RF[WRF_C]) begin
                r_flags[FLAG_C] <= in_flags[FLAG_C];
            end
            if (in_W_RF[WRF_V]) begin
                r_flags[FLAG_V] <= in_flags[FLAG_V];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_retired <= 32'd0;
        end else if (in_valid) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    assign out_flags   = r_flags;
    assign out_retired = r_retired;
    assign out_wb_en   = w_we;
    assign out_wb_addr = in_WC;
    assign out_wb_data = w_wb_data;

endmodule
